// File: rtl/load_store_unit.sv
// Load/store unit: turns one core request into one or two word beats with byte enables,
// splitting misaligned accesses and returning extended load data on a registered response.
module load_store_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {StIdle, StA0, StA1, StCap, StResp} state_e;

    state_e            state_q, state_d;
    logic              write_q, signed_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, beat0_q, rdata_q;

    logic [1:0]        off;
    logic [4:0]        shamt;
    logic [3:0]        base_be;
    logic [7:0]        lanes;
    logic              split;
    logic [63:0]       wdata_sh;
    logic [ADDR_W-3:0] word0;
    logic [63:0]       rd_pair;
    logic [31:0]       rd_sh;
    logic [31:0]       load_data;

    // Lane/shift decode works purely off the latched request, never the live req_* inputs.
    always_comb begin
        off   = addr_q[1:0];
        shamt = {off, 3'b000};
        word0 = addr_q[ADDR_W-1:2];
        case (size_q)
            2'b00:   base_be = 4'b1111;
            2'b01:   base_be = 4'b0011;
            2'b10:   base_be = 4'b0001;
            default: base_be = 4'b0000;
        endcase
        lanes    = {4'b0000, base_be} << off;
        split    = |lanes[7:4];
        wdata_sh = {32'h0, wdata_q} << shamt;
        rd_pair  = split ? {mem_rdata, beat0_q} : {32'h0, mem_rdata};
        rd_sh    = 32'(rd_pair >> shamt);
        case (size_q)
            2'b10:   load_data = {{24{signed_q & rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_data = {{16{signed_q & rd_sh[15]}}, rd_sh[15:0]};
            default: load_data = rd_sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid) state_d = (req_size == 2'b11) ? StResp : StA0;
            StA0:    state_d = split ? StA1 : StCap;
            StA1:    state_d = StCap;
            StCap:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        case (state_q)
            StA0: begin
                mem_en    = 1'b1;
                mem_we    = write_q;
                mem_be    = lanes[3:0];
                mem_addr  = word0;
                mem_wdata = wdata_sh[31:0];
            end
            StA1: begin
                mem_en    = 1'b1;
                mem_we    = write_q;
                mem_be    = lanes[7:4];
                mem_addr  = word0 + {{(ADDR_W-3){1'b0}}, 1'b1};
                mem_wdata = wdata_sh[63:32];
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            beat0_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                if (req_size == 2'b11) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
            // Beat-0 read data arrives while the second beat is on the bus.
            if (state_q == StA1) beat0_q <= mem_rdata;
            if (state_q == StCap) begin
                err_q   <= 1'b0;
                rdata_q <= write_q ? 32'h0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-wide memory model behind the port, expected
// beats and responses queued at issue time and checked by negedge monitors.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [7:0]  req_addr = 8'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [64] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        string       nm;
        logic        we;
        logic [3:0]  be;
        logic [5:0]  addr;
        logic [31:0] wd;
        int          cyc;
    } beat_t;

    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    beat_t mb;
    rsp_t  mr;
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en) begin
            if (beat_q.size() == 0) begin
                chk("unexpected beat", 64'd1, 64'd0);
            end else begin
                mb = beat_q.pop_front();
                chk({mb.nm, " beat we"}, 64'(mem_we), 64'(mb.we));
                chk({mb.nm, " beat be"}, 64'(mem_be), 64'(mb.be));
                chk({mb.nm, " beat addr"}, 64'(mem_addr), 64'(mb.addr));
                chk({mb.nm, " beat wdata"}, 64'(mem_wdata), 64'(mb.wd));
                chk({mb.nm, " beat cycle"}, 64'(cyc), 64'(mb.cyc));
            end
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected rsp_valid", 64'd1, 64'd0);
            end else begin
                mr = rsp_q.pop_front();
                chk({mr.nm, " rdata"}, 64'(rsp_rdata), 64'(mr.rd));
                chk({mr.nm, " err"}, 64'(rsp_err), 64'(mr.err));
                chk({mr.nm, " rsp cycle"}, 64'(cyc), 64'(mr.cyc));
            end
        end
    end

    // nb = number of beats the request should produce (0 for illegal size).
    task automatic issue(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] wd, input int nb,
                         input logic [3:0] be0, input logic [31:0] bw0,
                         input logic [3:0] be1, input logic [31:0] bw1,
                         input logic [31:0] exp_rd, input logic exp_err, input bit push_rsp);
        bit         rdy;
        int         acc;
        int         lat;
        beat_t      b;
        rsp_t       r;
        logic [5:0] w;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        rdy = 1'b0;
        w = a[7:2];
        for (int i = 0; i < 60 && !rdy; i++) begin
            rdy = req_ready;
            acc = cyc;
            if (rdy) begin
                if (nb >= 1) begin
                    b = '{nm, wr, be0, w, bw0, acc + 1};
                    beat_q.push_back(b);
                end
                if (nb == 2) begin
                    b = '{nm, wr, be1, w + 6'd1, bw1, acc + 2};
                    beat_q.push_back(b);
                end
                lat = (nb == 0) ? 1 : (nb == 2) ? 4 : 3;
                if (push_rsp) begin
                    r = '{nm, exp_rd, exp_err, acc + lat};
                    rsp_q.push_back(r);
                end
            end
            @(posedge clk);
            if (!rdy) @(negedge clk);
        end
        if (!rdy) chk({nm, " accept timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic ld(input string nm, input logic [1:0] sz, input logic sg, input logic [7:0] a,
                      input int nb, input logic [3:0] be0, input logic [3:0] be1,
                      input logic [31:0] exp_rd);
        issue(nm, 1'b0, sz, sg, a, 32'h0, nb, be0, 32'h0, be1, 32'h0, exp_rd, 1'b0, 1'b1);
    endtask

    task automatic st(input string nm, input logic [1:0] sz, input logic [7:0] a,
                      input logic [31:0] wd, input int nb, input logic [3:0] be0,
                      input logic [31:0] bw0, input logic [3:0] be1, input logic [31:0] bw1);
        issue(nm, 1'b1, sz, 1'b0, a, wd, nb, be0, bw0, be1, bw1, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (beat_q.size() == 0 && rsp_q.size() == 0 && req_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            chk({nm, " drain timeout"}, 64'd0, 64'd1);
            beat_q.delete();
            rsp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset mem_en", 64'(mem_en), 64'd0);
        chk("reset mem_we", 64'(mem_we), 64'd0);
        chk("reset mem_be", 64'(mem_be), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset mem_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        st("sw 08", 2'b00, 8'h08, 32'h00000011, 1, 4'b1111, 32'h00000011, 4'b0000, 32'h0);
        ld("lw 08", 2'b00, 1'b0, 8'h08, 1, 4'b1111, 4'b0000, 32'h00000011);
        st("sw 04", 2'b00, 8'h04, 32'hFE008000, 1, 4'b1111, 32'hFE008000, 4'b0000, 32'h0);
        ld("lb 05", 2'b10, 1'b1, 8'h05, 1, 4'b0010, 4'b0000, 32'hFFFFFF80);
        ld("lbu 05", 2'b10, 1'b0, 8'h05, 1, 4'b0010, 4'b0000, 32'h00000080);
        st("sb 08", 2'b10, 8'h08, 32'h000000FF, 1, 4'b0001, 32'h000000FF, 4'b0000, 32'h0);
        ld("lh 07", 2'b01, 1'b1, 8'h07, 2, 4'b1000, 4'b0001, 32'hFFFFFFFE);
        st("sw 0e", 2'b00, 8'h0E, 32'hAABBCCDD, 2, 4'b1100, 32'hCCDD0000, 4'b0011, 32'h0000AABB);
        ld("lw 0e", 2'b00, 1'b0, 8'h0E, 2, 4'b1100, 4'b0011, 32'hAABBCCDD);
        ld("lhu 0d", 2'b01, 1'b0, 8'h0D, 1, 4'b0110, 4'b0000, 32'h0000DD00);
        st("sw fc", 2'b00, 8'hFC, 32'h33221100, 1, 4'b1111, 32'h33221100, 4'b0000, 32'h0);
        st("sw 00", 2'b00, 8'h00, 32'h00000044, 1, 4'b1111, 32'h00000044, 4'b0000, 32'h0);
        ld("lw fd wrap", 2'b00, 1'b0, 8'hFD, 2, 4'b1110, 4'b0001, 32'h44332211);
        wait_idle("basic");

        issue("illegal", 1'b0, 2'b11, 1'b0, 8'h08, 32'h0, 0, 4'b0, 32'h0, 4'b0, 32'h0,
              32'h0, 1'b1, 1'b1);
        wait_idle("illegal");
        repeat (2) @(negedge clk);
        chk("illegal err hold", 64'(rsp_err), 64'd1);
        chk("illegal rdata hold", 64'(rsp_rdata), 64'd0);

        // Back-to-back: req_valid stays high while the unit is busy.
        ld("b2b lbu 05", 2'b10, 1'b0, 8'h05, 1, 4'b0010, 4'b0000, 32'h00000080);
        ld("b2b lhu 06", 2'b01, 1'b0, 8'h06, 1, 4'b1100, 4'b0000, 32'h0000FE00);
        ld("b2b lh 06", 2'b01, 1'b1, 8'h06, 1, 4'b1100, 4'b0000, 32'hFFFFFE00);
        st("sb 21", 2'b10, 8'h21, 32'h123456AB, 1, 4'b0010, 32'h3456AB00, 4'b0000, 32'h0);
        st("sh 22", 2'b01, 8'h22, 32'h0000BEEF, 1, 4'b1100, 32'hBEEF0000, 4'b0000, 32'h0);
        ld("lw 20", 2'b00, 1'b0, 8'h20, 1, 4'b1111, 4'b0000, 32'hBEEFAB00);
        wait_idle("b2b");

        // Reset asserted while the second beat of a split load is on the bus.
        issue("rst in A1", 1'b0, 2'b00, 1'b0, 8'h0E, 32'h0, 2, 4'b1100, 32'h0, 4'b0011, 32'h0,
              32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort mem_en", 64'(mem_en), 64'd0);
        chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort req_ready", 64'(req_ready), 64'd1);
        chk("abort rsp_rdata", 64'(rsp_rdata), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wait_idle("abort");

        ld("lw 08 after rst", 2'b00, 1'b0, 8'h08, 1, 4'b1111, 4'b0000, 32'h000000FF);
        wait_idle("final");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the unified byte-addressed data memory port. Accepts one load/store request at a time from the execute stage, turns it into one or two word-wide memory beats with byte enables, and splits misaligned accesses. Returns little-endian-aligned, sign- or zero-extended load data on a registered response. Sits between the EX/MEM pipeline boundary and the memory's data port.

## Interface
- ADDR_W, 8, byte-address width; memory word address is ADDR_W-2 bits
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; request taken when req_valid && req_ready at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal (same encoding as AU_inst_sel)
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse, response available
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; 1 = illegal size
- mem_en  out  1  memory beat this cycle
- mem_we  out  1  beat is a write
- mem_be  out  4  byte-lane enables, bit i = byte lane i
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  read data, valid the cycle after a mem_en && !mem_we beat

## Operation
- States: IDLE, A0, A1, CAP, RESP. req_ready = 1 only in IDLE.
- IDLE: on accept, latch write/size/signed/addr/wdata. size 11 -> RESP with err; else -> A0.
- off = addr[1:0]; lanes[7:0] = {0001 byte, 0011 half, 1111 word} << off; split = lanes[7:4] != 0 (byte never; half when off=3; word when off!=0).
- A0: mem_en=1, mem_we=write, mem_addr=addr[ADDR_W-1:2], mem_be=lanes[3:0], mem_wdata=(wdata<<8*off)[31:0]. -> A1 if split else CAP.
- A1: mem_en=1, mem_addr = first word + 1 modulo 2^(ADDR_W-2) (wraps to 0), mem_be=lanes[7:4], mem_wdata=(wdata<<8*off)[63:32]; capture beat-0 mem_rdata. -> CAP.
- CAP: no beat; capture last-beat mem_rdata (beat 0 if not split). Assemble {beat1, beat0} >> 8*off, mask to size, extend from bit 7 (byte) / bit 15 (half) per signed; register into rsp_rdata. -> RESP.
- RESP: rsp_valid=1 for this cycle only, rsp_err per latched size. -> IDLE.
- Stores: same path, rdata ignored, rsp_rdata=0.
- Outside A0/A1: mem_en, mem_we, mem_be, mem_addr, mem_wdata all 0.
- mem_* decoded only from state and latched request; no combinational path req_* -> mem_*.

## Timing
- Reset (rst_n low at an edge): state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; all mem_* 0; latched request and capture registers cleared.
- Reset mid-operation (any state): abort, no further beats, no response; next cycle is IDLE.
- Accept at edge t: aligned -> A0 in t+1, CAP t+2, RESP (rsp_valid) t+3. Split -> A0 t+1, A1 t+2, CAP t+3, RESP t+4. Illegal -> RESP t+1, zero beats.
- Next accept earliest at edge ending RESP+1 cycle (IDLE); req_valid during busy states is held off, not dropped.
- rsp_rdata/rsp_err hold their values until the next RESP or reset.

## Test plan
- Aligned LW addr 0x08, memory word 2 = 0x00000011 -> single beat word 2 be 1111 in t+1; rsp_valid t+3, rdata 0x00000011, err 0.
- LB addr 0x05, word 1 = 0x00008000: signed -> rdata 0xFFFFFF80; LBU -> 0x00000080; beat be 0010.
- Misaligned LH signed addr 0x07, byte 0x07=0xFE, byte 0x08=0xFF -> beats word 1 be 1000, word 2 be 0001; rsp_valid t+4, rdata 0xFFFFFFFE.
- Misaligned SW addr 0x0E data 0xAABBCCDD -> beat word 3 be 1100 wdata 0xCCDD0000, then word 4 be 0011 wdata 0x0000AABB; rsp_rdata 0.
- Wrap: ADDR_W=8, LW addr 0xFD -> word 63 be 1110 then word 0 be 0001; rdata = {byte0x00, byte0xFF, byte0xFE, byte0xFD}.
- req_size 11 -> no mem_en, rsp_valid t+1 with err 1, rdata 0; separately rst_n low during A1 -> mem_en 0 next cycle, no rsp_valid, req_ready 1.
